// File: rtl/ir_cmd_rx.sv
// NEC infrared remote receiver with play/pause and stop control.
// Frames and repeats are timed in quarter-unit ticks of a shared counter.
module ir_cmd_rx #(
  parameter int         QUNIT      = 7031,
  parameter logic [7:0] ADDR_MATCH = 8'h00,
  parameter logic [7:0] PLAY_CODE  = 8'h43,
  parameter logic [7:0] STOP_CODE  = 8'h45
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ir_in,
  output logic       play_pause,
  output logic       stop,
  output logic [7:0] cmd,
  output logic [7:0] addr,
  output logic       cmd_valid,
  output logic       rpt,
  output logic       err
);

  localparam int PW = (QUNIT > 1) ? $clog2(QUNIT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(QUNIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_LO,
    S_LEAD_HI,
    S_BIT_LO,
    S_BIT_HI,
    S_STOP_LO
  } state_t;

  state_t r_state, w_next;

  logic          r_sync1, r_sync2, r_sync3;
  logic [PW-1:0] r_pre;
  logic [6:0]    r_width;
  logic [5:0]    r_bitcnt;
  logic [31:0]   r_sr;
  logic          r_rep, r_have;
  logic          r_play, r_stop;
  logic [7:0]    r_cmd, r_addr;
  logic          r_cmd_valid, r_rpt, r_err;

  logic       w_fall, w_rise, w_edge;
  logic       w_lead, w_hdr, w_rhdr, w_short, w_long;
  logic [6:0] w_max;
  logic       w_tmo;
  logic       w_err, w_shift, w_bit, w_clr_bits, w_set_rep, w_done;
  logic       w_chk_ok;
  logic [7:0] w_b0, w_b1, w_b2, w_b3;

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_rise = ~r_sync3 & r_sync2;
  assign w_edge = w_fall | w_rise;

  assign w_lead  = (r_width >= 7'd56) && (r_width <= 7'd72);
  assign w_hdr   = (r_width >= 7'd28) && (r_width <= 7'd36);
  assign w_rhdr  = (r_width >= 7'd12) && (r_width <= 7'd20);
  assign w_short = (r_width >= 7'd2)  && (r_width <= 7'd6);
  assign w_long  = (r_width >= 7'd9)  && (r_width <= 7'd15);

  assign w_b0 = r_sr[7:0];
  assign w_b1 = r_sr[15:8];
  assign w_b2 = r_sr[23:16];
  assign w_b3 = r_sr[31:24];
  assign w_chk_ok = (w_b1 == ~w_b0) && (w_b3 == ~w_b2);

  assign play_pause = r_play;
  assign stop       = r_stop;
  assign cmd        = r_cmd;
  assign addr       = r_addr;
  assign cmd_valid  = r_cmd_valid;
  assign rpt        = r_rpt;
  assign err        = r_err;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= ir_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Quarter-unit width counter, restarted by every edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre   <= '0;
      r_width <= '0;
    end else if (w_edge) begin
      r_pre   <= '0;
      r_width <= '0;
    end else if (r_pre == PMAX) begin
      r_pre <= '0;
      if (r_width != 7'd127)
        r_width <= r_width + 7'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Longest legal width in each state before it counts as a timeout
  always_comb begin
    w_max = 7'd127;
    unique case (r_state)
      S_IDLE:    w_max = 7'd127;
      S_LEAD_LO: w_max = 7'd72;
      S_LEAD_HI: w_max = 7'd36;
      S_BIT_LO:  w_max = 7'd6;
      S_BIT_HI:  w_max = 7'd15;
      S_STOP_LO: w_max = 7'd6;
      default:   w_max = 7'd127;
    endcase
  end

  assign w_tmo = r_width > w_max;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next state: an edge always wins over a coincident timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_fall) w_next = S_LEAD_LO;
      S_LEAD_LO:
        if (w_rise)
          w_next = w_lead ? S_LEAD_HI : S_IDLE;
        else if (w_tmo)
          w_next = S_IDLE;
      S_LEAD_HI:
        if (w_fall) begin
          if (w_hdr)       w_next = S_BIT_LO;
          else if (w_rhdr) w_next = S_STOP_LO;
          else             w_next = S_IDLE;
        end else if (w_tmo)
          w_next = S_IDLE;
      S_BIT_LO:
        if (w_rise)
          w_next = w_short ? S_BIT_HI : S_IDLE;
        else if (w_tmo)
          w_next = S_IDLE;
      S_BIT_HI:
        if (w_fall) begin
          if (w_short || w_long)
            w_next = (r_bitcnt == 6'd31) ? S_STOP_LO : S_BIT_LO;
          else
            w_next = S_IDLE;
        end else if (w_tmo)
          w_next = S_IDLE;
      S_STOP_LO:
        if (w_rise || w_tmo)
          w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Per-state actions for the datapath
  always_comb begin
    w_err      = 1'b0;
    w_shift    = 1'b0;
    w_bit      = 1'b0;
    w_clr_bits = 1'b0;
    w_set_rep  = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_LEAD_LO:
        if (w_rise) w_err = ~w_lead;
        else        w_err = w_tmo;
      S_LEAD_HI:
        if (w_fall) begin
          if (w_hdr)       w_clr_bits = 1'b1;
          else if (w_rhdr) w_set_rep  = 1'b1;
          else             w_err      = 1'b1;
        end else
          w_err = w_tmo;
      S_BIT_LO:
        if (w_rise) w_err = ~w_short;
        else        w_err = w_tmo;
      S_BIT_HI:
        if (w_fall) begin
          if (w_short) begin
            w_shift = 1'b1;
          end else if (w_long) begin
            w_shift = 1'b1;
            w_bit   = 1'b1;
          end else
            w_err = 1'b1;
        end else
          w_err = w_tmo;
      S_STOP_LO:
        if (w_rise) begin
          w_done = w_short;
          w_err  = ~w_short;
        end else
          w_err = w_tmo;
      default: ;
    endcase
  end

  // Bit shifter, bit counter and repeat flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr     <= '0;
      r_bitcnt <= '0;
      r_rep    <= 1'b0;
    end else begin
      if (w_clr_bits) begin
        r_bitcnt <= '0;
        r_rep    <= 1'b0;
      end
      if (w_set_rep)
        r_rep <= 1'b1;
      if (w_shift) begin
        r_sr     <= {w_bit, r_sr[31:1]};
        r_bitcnt <= r_bitcnt + 6'd1;
      end
    end
  end

  // Frame completion: pulses, captured bytes and transport state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_rpt       <= 1'b0;
      r_err       <= 1'b0;
      r_have      <= 1'b0;
      r_cmd       <= 8'h00;
      r_addr      <= 8'h00;
      r_play      <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_rpt       <= 1'b0;
      r_err       <= w_err;
      if (w_done) begin
        if (r_rep) begin
          r_rpt <= r_have;
          r_err <= ~r_have;
        end else if (w_chk_ok) begin
          r_cmd_valid <= 1'b1;
          r_addr      <= w_b0;
          r_cmd       <= w_b2;
          r_have      <= 1'b1;
          if (w_b0 == ADDR_MATCH) begin
            if (w_b2 == PLAY_CODE) begin
              r_play <= ~r_play;
              r_stop <= 1'b0;
            end else if (w_b2 == STOP_CODE) begin
              r_play <= 1'b0;
              r_stop <= 1'b1;
            end
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_cmd_rx.sv
// Bench for ir_cmd_rx: NEC frames with jittered timing.
// Expected outputs come from a frame-level model of the remote protocol.
module tb_ir_cmd_rx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ir_in = 1'b1;
  logic       play_pause, stop;
  logic [7:0] cmd, addr;
  logic       cmd_valid, rpt, err;

  ir_cmd_rx #(.QUNIT(4)) dut (
    .clock(clock), .reset_n(reset_n), .ir_in(ir_in),
    .play_pause(play_pause), .stop(stop),
    .cmd(cmd), .addr(addr),
    .cmd_valid(cmd_valid), .rpt(rpt), .err(err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_valid = 0, n_rpt = 0, n_err = 0, n_multi = 0;
  int last_cyc = 0;
  logic pp_q = 1'b0, v_pp = 1'b0, v_st = 1'b0, v_pp_prev = 1'b0;

  logic       m_play, m_stop, m_have;
  logic [7:0] m_cmd, m_addr;

  int s_v, s_r, s_e, drive_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge
  always @(negedge clock) begin
    pp_q <= play_pause;
    if (cmd_valid) begin
      n_valid   <= n_valid + 1;
      v_pp      <= play_pause;
      v_st      <= stop;
      v_pp_prev <= pp_q;
    end
    if (rpt) n_rpt <= n_rpt + 1;
    if (err) n_err <= n_err + 1;
    if (cmd_valid || rpt || err) last_cyc <= cyc;
    if (int'(cmd_valid) + int'(rpt) + int'(err) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int cycles);
    ir_in = lvl;
    repeat (cycles) @(negedge clock);
  endtask

  function automatic int dur(input int q);
    return 4 * (q - 1 + int'($urandom_range(0, 2)))
           + int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    m_play = 1'b0; m_stop = 1'b0; m_have = 1'b0;
    m_cmd = 8'h00; m_addr = 8'h00;
  endtask

  task automatic snap();
    s_v = n_valid; s_r = n_rpt; s_e = n_err;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nb);
    hold(1'b0, dur(64));
    hold(1'b1, dur(32));
    for (int i = 0; i < nb; i++) begin
      hold(1'b0, dur(4));
      hold(1'b1, dur(w[i] ? 12 : 4));
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".play"}, {31'd0, play_pause}, {31'd0, m_play});
    chk({tag, ".stop"}, {31'd0, stop}, {31'd0, m_stop});
    chk({tag, ".cmd"}, {24'd0, cmd}, {24'd0, m_cmd});
    chk({tag, ".addr"}, {24'd0, addr}, {24'd0, m_addr});
  endtask

  task automatic check_pulses(input string tag, input int ev,
                              input int er, input int ee);
    chk({tag, ".nvalid"}, n_valid - s_v, ev);
    chk({tag, ".nrpt"}, n_rpt - s_r, er);
    chk({tag, ".nerr"}, n_err - s_e, ee);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3);
    logic ok;
    logic old_play;
    snap();
    send_bits({b3, b2, b1, b0}, 32);
    hold(1'b0, dur(4));
    ir_in = 1'b1;
    drive_cyc = cyc;
    repeat (150) @(negedge clock);
    ok = (b1 == ~b0) && (b3 == ~b2);
    old_play = m_play;
    if (ok) begin
      m_have = 1'b1; m_addr = b0; m_cmd = b2;
      if (b0 == 8'h00 && b2 == 8'h43) begin
        m_play = ~m_play; m_stop = 1'b0;
      end else if (b0 == 8'h00 && b2 == 8'h45) begin
        m_play = 1'b0; m_stop = 1'b1;
      end
    end
    check_pulses(tag, ok ? 1 : 0, 0, ok ? 0 : 1);
    check_state(tag);
    if (ok) begin
      chk({tag, ".lat"}, last_cyc - drive_cyc, 3);
      chk({tag, ".pp_at_pulse"}, {31'd0, v_pp}, {31'd0, m_play});
      chk({tag, ".st_at_pulse"}, {31'd0, v_st}, {31'd0, m_stop});
      chk({tag, ".pp_before"}, {31'd0, v_pp_prev}, {31'd0, old_play});
    end
  endtask

  task automatic do_repeat(input string tag);
    snap();
    hold(1'b0, dur(64));
    hold(1'b1, dur(16));
    hold(1'b0, dur(4));
    ir_in = 1'b1;
    repeat (150) @(negedge clock);
    check_pulses(tag, 0, m_have ? 1 : 0, m_have ? 0 : 1);
    check_state(tag);
  endtask

  task automatic good(input string tag, input logic [7:0] a,
                      input logic [7:0] c);
    do_frame(tag, a, ~a, c, ~c);
  endtask

  initial begin
    logic [7:0] a, c, b1, b3;
    model_reset();
    repeat (5) @(negedge clock);
    chk("rst.valid", {31'd0, cmd_valid}, 0);
    chk("rst.rpt", {31'd0, rpt}, 0);
    chk("rst.err", {31'd0, err}, 0);
    check_state("rst");
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    do_repeat("rpt_no_last");
    good("play1", 8'h00, 8'h43);
    good("play2", 8'h00, 8'h43);
    do_repeat("rpt_after");
    good("play3", 8'h00, 8'h43);
    good("stopc", 8'h00, 8'h45);
    do_frame("bad_b3", 8'h00, 8'hFF, 8'h43, 8'hBD);
    good("other_addr", 8'h12, 8'h43);

    snap();
    send_bits($urandom, 10);
    hold(1'b0, dur(4));
    hold(1'b1, 80);
    repeat (100) @(negedge clock);
    check_pulses("timeout", 0, 0, 1);
    check_state("timeout");

    snap();
    send_bits($urandom, 9);
    hold(1'b0, dur(4));
    ir_in = 1'b1;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (150) @(negedge clock);
    check_pulses("midrst", 0, 0, 0);
    check_state("midrst");
    good("post_rst", 8'h00, 8'h43);

    for (int k = 0; k < 6; k++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 2))
        0: c = 8'h43;
        1: c = 8'h45;
        default: c = 8'($urandom);
      endcase
      b1 = ~a;
      b3 = ~c;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          b1 = b1 ^ (8'h01 << $urandom_range(0, 7));
        else
          b3 = b3 ^ (8'h01 << $urandom_range(0, 7));
      end
      do_frame($sformatf("rnd%0d", k), a, b1, c, b3);
      if ($urandom_range(0, 2) == 0)
        do_repeat($sformatf("rnd_rpt%0d", k));
    end

    chk("exclusive", n_multi, 0);
    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
